// File: rtl/stream_cipher_if.sv
// ----------------------------------------------------------------------------
// stream_cipher_if
// Byte-stream bus for stream_cipher_core.
//   key_in     : key-load strobe (master -> core)
//   key[7:0]   : key value, used when key_in = 1 (master -> core)
//   din[7:0]   : input byte (master -> core)
//   din_valid  : din qualifier (master -> core)
//   dout[7:0]  : output byte, registered (core -> master)
//   dout_valid : dout qualifier, registered (core -> master)
// ----------------------------------------------------------------------------
interface stream_cipher_if;
    logic       key_in;
    logic [7:0] key;
    logic [7:0] din;
    logic       din_valid;
    logic [7:0] dout;
    logic       dout_valid;

    modport master (
        output key_in, key, din, din_valid,
        input  dout, dout_valid
    );

    modport slave (
        input  key_in, key, din, din_valid,
        output dout, dout_valid
    );
endinterface

// File: rtl/stream_cipher_core.sv
// ----------------------------------------------------------------------------
// stream_cipher_core
// XOR stream cipher. Each accepted byte is XORed with AES_SBOX[(K + I) mod 256],
// where K is the loaded key and I is the running byte offset since the last
// key load (or reset). Encryption and decryption are the same operation.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset (K, I, dout, dout_valid -> 0)
//   bus   : stream_cipher_if.slave (key_in/key, din/din_valid, dout/dout_valid)
// Latency is one cycle; a byte can be accepted every cycle. Outputs come
// straight from flops, so there is no input-to-output combinational path.
// ----------------------------------------------------------------------------
module stream_cipher_core (
    input  logic              clk,
    input  logic              rst_n,
    stream_cipher_if.slave    bus
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [7:0] key_reg,   key_next;
    logic [7:0] idx_reg,   idx_next;
    logic [7:0] dout_reg,  dout_next;
    logic       valid_reg, valid_next;
    logic [7:0] ks_addr;
    logic [7:0] ks_byte;

    // 8-bit sum wraps naturally, so the keystream period is 256 bytes.
    assign ks_addr = key_reg + idx_reg;
    assign ks_byte = SBOX[ks_addr];

    always_comb begin
        key_next   = key_reg;
        idx_next   = idx_reg;
        dout_next  = dout_reg;
        valid_next = 1'b0;
        if (bus.key_in) begin
            // Key load wins over a simultaneous data byte; that byte is dropped.
            key_next = bus.key;
            idx_next = 8'h00;
        end else if (bus.din_valid) begin
            dout_next  = bus.din ^ ks_byte;
            valid_next = 1'b1;
            idx_next   = idx_reg + 8'h01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg   <= 8'h00;
            idx_reg   <= 8'h00;
            dout_reg  <= 8'h00;
            valid_reg <= 1'b0;
        end else begin
            key_reg   <= key_next;
            idx_reg   <= idx_next;
            dout_reg  <= dout_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.dout       = dout_reg;
    assign bus.dout_valid = valid_reg;

endmodule

// File: tb/tb_stream_cipher_core.sv
// ----------------------------------------------------------------------------
// tb_stream_cipher_core
// Self-checking bench for stream_cipher_core. The reference S-box is computed
// from the GF(2^8) inverse plus the AES affine map, so it does not share a
// table with the design. Expected output bytes are pushed to a queue when a
// byte is driven and popped when the core presents dout_valid.
// ----------------------------------------------------------------------------
module tb_stream_cipher_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_cipher_if bus ();

    stream_cipher_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_ref [256];
    logic [7:0] m_key, m_idx, m_dout;
    logic       m_valid;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            if (a[7]) a = (a << 1) ^ 8'h1b;
            else      a = a << 1;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_ref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    // Drives one cycle of stimulus, updates the model, returns #1 after the edge.
    task automatic drive(input logic kin, input logic [7:0] k, input logic dv, input logic [7:0] d);
        logic [7:0] addr;
        @(negedge clk);
        bus.key_in = kin; bus.key = k; bus.din_valid = dv; bus.din = d;
        if (kin) begin
            m_key = k; m_idx = 8'h00; m_valid = 1'b0;
        end else if (dv) begin
            addr = m_key + m_idx;
            m_dout = d ^ sbox_ref[addr];
            exp_q.push_back(m_dout);
            m_idx = m_idx + 8'h01;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_key = 8'h00; m_idx = 8'h00; m_dout = 8'h00; m_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: dout=%h valid=%b required dout=00 valid=0", bus.dout, bus.dout_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        // No key loaded: behaves as key 0x00.
        drive(1'b0, 8'h00, 1'b1, 8'h00);
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h63) begin
            errors++;
            $display("FAIL post_reset_key0: dout=%h valid=%b required dout=63 valid=1", bus.dout, bus.dout_valid);
        end
        void'(exp_q.pop_front());
        $display("reset: din=00 -> dout=%h", bus.dout);
    endtask

    task automatic test_basic();
        logic [7:0] lit [4];
        logic [7:0] din_t [4];
        logic       dv_t [4];
        lit = '{8'h63, 8'h7d, 8'hcb, 8'h64};
        // Key 0x00 then 0x00, 0x01 back to back.
        drive(1'b1, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'(i));
            exp_b = exp_q.pop_front();
            checks++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== exp_b || bus.dout !== lit[i]) begin
                errors++;
                $display("FAIL basic_k00[%0d]: dout=%h valid=%b required dout=%h valid=1", i, bus.dout, bus.dout_valid, lit[i]);
            end
            $display("basic k=00 din=%h -> dout=%h", 8'(i), bus.dout);
        end
        // Key 0x41: byte, idle, byte.
        drive(1'b1, 8'h41, 1'b0, 8'h00);
        din_t = '{8'h48, 8'h00, 8'h48, 8'h00};
        dv_t  = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, dv_t[i], din_t[i]);
            checks++;
            if (bus.dout_valid !== m_valid) begin
                errors++;
                $display("FAIL basic_k41_valid[%0d]: valid=%b required %b", i, bus.dout_valid, m_valid);
            end
            checks++;
            if (m_valid) begin
                exp_b = exp_q.pop_front();
                if (bus.dout !== exp_b || bus.dout !== lit[(i == 0) ? 2 : 3]) begin
                    errors++;
                    $display("FAIL basic_k41_dout[%0d]: dout=%h required %h", i, bus.dout, exp_b);
                end
            end else if (bus.dout !== 8'hcb) begin
                errors++;
                $display("FAIL basic_idle_hold: dout=%h required cb", bus.dout);
            end
            $display("basic k=41 dv=%b din=%h -> dout=%h valid=%b", dv_t[i], din_t[i], bus.dout, bus.dout_valid);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        drive(1'b1, 8'h00, 1'b0, 8'h00);
        for (int b = 0; b < 65536; b++) begin
            drive(1'b0, 8'h00, 1'b1, 8'(b));
            exp_b = exp_q.pop_front();
            checks++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== exp_b) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL sweep[%0d]: dout=%h valid=%b required dout=%h valid=1", b, bus.dout, bus.dout_valid, exp_b);
            end
        end
        $display("back_to_back: 65536 bytes streamed, %0d bad", bad);
    endtask

    task automatic test_roundtrip();
        string      text;
        logic [7:0] cipher [$];
        text = "Hello, FPGA stream cipher!";
        drive(1'b1, 8'h41, 1'b0, 8'h00);
        for (int i = 0; i < text.len(); i++) begin
            drive(1'b0, 8'h00, 1'b1, text[i]);
            exp_b = exp_q.pop_front();
            checks++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== exp_b) begin
                errors++;
                $display("FAIL encrypt[%0d]: dout=%h valid=%b required dout=%h valid=1", i, bus.dout, bus.dout_valid, exp_b);
            end
            cipher.push_back(bus.dout);
            $display("encrypt '%s' -> %h", string'(text[i]), bus.dout);
            drive(1'b0, 8'h00, 1'b0, 8'h00);
            checks++;
            if (bus.dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL encrypt_gap[%0d]: valid=%b required 0", i, bus.dout_valid);
            end
        end
        drive(1'b1, 8'h41, 1'b0, 8'h00);
        for (int i = 0; i < cipher.size(); i++) begin
            drive(1'b0, 8'h00, 1'b1, cipher[i]);
            exp_b = exp_q.pop_front();
            checks++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== text[i] || bus.dout !== exp_b) begin
                errors++;
                $display("FAIL decrypt[%0d]: dout=%h valid=%b required dout=%h valid=1", i, bus.dout, bus.dout_valid, text[i]);
            end
            $display("decrypt %h -> %h", cipher[i], bus.dout);
        end
    endtask

    task automatic test_rekey();
        drive(1'b1, 8'h10, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'h5a);
            void'(exp_q.pop_front());
        end
        drive(1'b1, 8'h10, 1'b0, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 8'h5a);
        exp_b = exp_q.pop_front();
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== exp_b || bus.dout !== (8'h5a ^ sbox_ref[8'h10])) begin
            errors++;
            $display("FAIL rekey_offset0: dout=%h valid=%b required dout=%h valid=1", bus.dout, bus.dout_valid, exp_b);
        end
        $display("rekey k=10 din=5a -> dout=%h", bus.dout);
        // Key load and data on the same edge: data dropped.
        drive(1'b1, 8'h20, 1'b1, 8'hff);
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL key_priority: valid=%b required 0", bus.dout_valid);
        end
        drive(1'b0, 8'h00, 1'b1, 8'h00);
        exp_b = exp_q.pop_front();
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== exp_b || bus.dout !== sbox_ref[8'h20]) begin
            errors++;
            $display("FAIL key_priority_next: dout=%h valid=%b required dout=%h valid=1", bus.dout, bus.dout_valid, exp_b);
        end
        $display("key_priority k=20 din=00 -> dout=%h", bus.dout);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'h77, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'(i + 8'h30));
            void'(exp_q.pop_front());
        end
        // Assert reset between edges with data still valid on the inputs.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: dout=%h valid=%b required dout=00 valid=0", bus.dout, bus.dout_valid);
        end
        bus.din_valid = 1'b0;
        model_reset();
        @(posedge clk); #2;
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 8'h00);
        exp_b = exp_q.pop_front();
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== exp_b || bus.dout !== 8'h63) begin
            errors++;
            $display("FAIL async_reset_release: dout=%h valid=%b required dout=63 valid=1", bus.dout, bus.dout_valid);
        end
        $display("async_reset release din=00 -> dout=%h", bus.dout);
    endtask

    initial begin
        bus.key_in = 1'b0; bus.key = 8'h00; bus.din = 8'h00; bus.din_valid = 1'b0;
        build_sbox();
        test_reset();
        test_basic();
        test_back_to_back();
        test_roundtrip();
        test_rekey();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
